draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of glyph-drawer requesters.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum number of DRAW cycles per grant (timeout build only).
REQ-003 clk  input  1: system clock, 50 MHz, all state on rising edge.
REQ-004 resetn  input  1: reset, asynchronous, active-low; one clock domain only.
REQ-005 req  input  NUM_REQ: per-drawer request-to-draw level.
REQ-006 done  input  NUM_REQ: per-drawer glyph-complete pulse.
REQ-007 plot_in  input  NUM_REQ: per-drawer pixel-valid strobe.
REQ-008 x_in  input  NUM_REQ*8: per-drawer X coordinate, drawer i at bits [8i+7:8i].
REQ-009 y_in  input  NUM_REQ*7: per-drawer Y coordinate, drawer i at bits [7i+6:7i].
REQ-010 colour_in  input  NUM_REQ*3: per-drawer RGB colour.
REQ-011 grant  output  NUM_REQ: one-hot or zero enable to the drawers.
REQ-012 vga_x  output  8 / vga_y  output  7 / vga_colour  output  3 / vga_plot  output  1: registered VGA adapter pixel port.
REQ-013 busy  output  1: high in any state other than IDLE.
REQ-014 timeout_err  output  1: one-cycle pulse on forced release.

Function
REQ-015 FSM states: IDLE, DRAW, RELEASE; RELEASE is exactly one cycle.
REQ-016 IDLE: on any req bit high, select the lowest-index requester at or after rr_ptr, wrapping modulo NUM_REQ; next cycle grant is one-hot on it and state is DRAW.
REQ-017 IDLE with req all zero: remain in IDLE; grant, vga_plot and busy stay 0.
REQ-018 DRAW: vga_x/vga_y/vga_colour/vga_plot register the granted drawer's x_in/y_in/colour_in/plot_in with one-cycle latency.
REQ-019 Non-granted drawers' plot_in and done are ignored.
REQ-020 DRAW exits to RELEASE on granted done=1; a pixel with plot_in=1 in that same cycle is still forwarded.
REQ-021 req deassertion during DRAW does not release the grant; only done or timeout releases it.
REQ-022 RELEASE: grant=0, vga_plot=0, rr_ptr = granted index + 1 (NUM_REQ-1 wraps to 0); next state IDLE.
REQ-023 vga_x/vga_y/vga_colour hold their last value outside DRAW; vga_plot is 0 outside DRAW.
REQ-024 At most one grant bit is high in any cycle.

Reset
REQ-025 resetn low asynchronously forces state IDLE, rr_ptr 0, grant 0, vga_x 0, vga_y 0, vga_colour 0, vga_plot 0, busy 0, timeout_err 0, and clears the timeout counter.
REQ-026 Reset mid-DRAW abandons the glyph; after release the first arbitration starts from index 0.

Configuration
REQ-027 With DRAW_ARB_TIMEOUT_EN defined, a 16-bit counter clears on DRAW entry and increments each DRAW cycle.
REQ-028 With DRAW_ARB_TIMEOUT_EN defined, a count reaching TIMEOUT_CYCLES-1 without done forces RELEASE and pulses timeout_err for one cycle.
REQ-029 Without DRAW_ARB_TIMEOUT_EN, no counter is built, timeout_err is tied 0, and DRAW waits for done indefinitely.

Structure
REQ-030 Shared package holds the FSM state encoding, coordinate widths (8 X, 7 Y), colour width (3), and the default TIMEOUT_CYCLES.
REQ-031 Round-robin selection lives in sub-module rr_select: inputs req, rr_ptr; outputs one-hot pick and binary index; purely combinational.

Verification
REQ-032 Scenario, single drawer: req=4'b0100 -> grant=4'b0100 one cycle later; 32 pixels with plot_in=1 appear on vga_* each one cycle delayed; done -> grant=0 after RELEASE; rr_ptr=3.
REQ-033 Scenario, contention: req=4'b1111 held with rr_ptr=0 -> grants in order 0,1,2,3,0 with one RELEASE cycle between grants.
REQ-034 Scenario, wrap-around: rr_ptr=3 and req=4'b1001 -> grant 3, then grant 0.
REQ-035 Scenario, ignore non-granted: drawer 1 granted; drawer 2 pulses done and plot_in -> no release and no vga_plot from drawer 2.
REQ-036 Scenario, timeout (macro on, TIMEOUT_CYCLES=16): granted drawer never asserts done -> release after 16 DRAW cycles, timeout_err high for exactly 1 cycle; macro off -> grant held for 1000 cycles.
REQ-037 Scenario, reset mid-DRAW: resetn low at cycle 10 of a grant -> all outputs 0 asynchronously; after release req=4'b0110 -> grant 4'b0010.

Source files
------------

// File: rtl/draw_arbiter_pkg.sv
// Shared definitions for the glyph-drawer arbiter: FSM encoding, pixel field
// widths and the default per-grant timeout.
package draw_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/draw_arbiter_rr_select.sv
// Combinational round-robin picker: lowest requester at or after rr_ptr,
// wrapping modulo N. Returns a one-hot pick and its binary index.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   c;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(rr_ptr) + i) % N;
      if (!found && req[c]) begin
        found   = 1'b1;
        pick[c] = 1'b1;
        idx     = IW'(c);
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter granting one glyph drawer at a time the VGA pixel port.
// Optional per-grant watchdog is built only when DRAW_ARB_TIMEOUT_EN is defined.
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ-1:0]         plot_in,
  input  logic [NUM_REQ*X_W-1:0]     x_in,
  input  logic [NUM_REQ*Y_W-1:0]     y_in,
  input  logic [NUM_REQ*C_W-1:0]     colour_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_colour,
  output logic                       vga_plot,
  output logic                       busy,
  output logic                       timeout_err,
  output state_t                     state_dbg,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr_dbg
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a drawer holds req until granted; grant is one-hot while it owns
  // the port, its plot_in/x/y/colour are registered through, and a single done
  // pulse (or watchdog expiry) ends ownership with one RELEASE cycle.

  state_t            state, state_nx;
  logic [IW-1:0]     rr_ptr, gnt_idx, pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic              gnt_done, timeout_hit;

  rr_select #(.N(NUM_REQ), .IW(IW)) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx)
  );

  assign gnt_done   = done[gnt_idx];
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (|req) state_nx = ST_DRAW;
      ST_DRAW:    if (gnt_done || timeout_hit) state_nx = ST_RELEASE;
      ST_RELEASE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant   <= pick;
            gnt_idx <= pick_idx;
          end
        end
        ST_DRAW: begin
          vga_x      <= x_in[gnt_idx*X_W +: X_W];
          vga_y      <= y_in[gnt_idx*Y_W +: Y_W];
          vga_colour <= colour_in[gnt_idx*C_W +: C_W];
          vga_plot   <= plot_in[gnt_idx];
          if (state_nx == ST_RELEASE) begin
            grant  <= '0;
            rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DRAW_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Counter sits at zero while idle, so it is clear on the first DRAW cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == ST_DRAW) && timeout_hit && !gnt_done;
      if (state == ST_DRAW) to_cnt <= to_cnt + 16'd1;
      else                  to_cnt <= '0;
    end
  end

  assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed scenarios plus random traffic
// against a behavioural ownership model. Honours DRAW_ARB_TIMEOUT_EN.
module tb_draw_arbiter;
  import draw_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef DRAW_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0, done = '0, plot_in = '0;
  logic [N*8-1:0] x_in = '0;
  logic [N*7-1:0] y_in = '0;
  logic [N*3-1:0] colour_in = '0;
  logic [N-1:0]   grant;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, busy, timeout_err;
  state_t         state_dbg;
  logic [1:0]     rr_ptr_dbg;

  draw_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg),
    .rr_ptr_dbg(rr_ptr_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: who owns the port, and whether we are in the gap cycle
  int         m_owner, m_ptr, m_cnt;
  bit         m_rel, m_plot, m_err;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  int         grant_cycles, err_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_rel = 0; m_plot = 0; m_err = 0;
    m_x = '0; m_y = '0; m_c = '0;
  endtask

  task automatic model_next();
    m_plot = 0;
    m_err  = 0;
    if (m_rel) begin
      m_rel = 0;
    end else if (m_owner >= 0) begin
      m_x    = x_in[8*m_owner +: 8];
      m_y    = y_in[7*m_owner +: 7];
      m_c    = colour_in[3*m_owner +: 3];
      m_plot = plot_in[m_owner];
      if (done[m_owner] || (TO_EN && m_cnt == TO - 1)) begin
        m_err   = !done[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_rel   = 1;
      end else begin
        m_cnt++;
      end
    end else if (req != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("grant", grant, exp_grant);
    check("onehot", 32'($countones(grant) <= 1), 1);
    check("busy", busy, (m_owner >= 0) || m_rel);
    check("vga_plot", vga_plot, m_plot);
    check("vga_x", vga_x, m_x);
    check("vga_y", vga_y, m_y);
    check("vga_colour", vga_colour, m_c);
    check("timeout_err", timeout_err, m_err);
    check("rr_ptr", rr_ptr_dbg, m_ptr[1:0]);
    if (grant != '0) grant_cycles++;
    if (timeout_err) err_pulses++;
  endtask

  // driver tasks
  task automatic rand_pix();
    x_in      = N*8'($urandom);
    y_in      = N*7'($urandom);
    colour_in = N*3'($urandom);
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2 resetn = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_ptr", rr_ptr_dbg, 0);
    req = '0; done = '0; plot_in = '0;
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  int ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    async_reset();
    step();

    // single drawer: 32 forwarded pixels then done
    req = 4'b0100; step();
    check("single_grant", grant, 4'b0100);
    plot_in = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      rand_pix(); step();
      check("single_plot", vga_plot, 1);
    end
    done = 4'b0100; rand_pix(); step();
    check("single_last_pixel", vga_plot, 1);
    done = '0; req = '0; plot_in = '0; step();
    check("single_ptr", rr_ptr_dbg, 3);
    step();

    // contention from rr_ptr 0
    async_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("cont_order", grant, N'(1) << ord[k]);
      repeat ($urandom_range(0, 3)) begin rand_pix(); plot_in = N'($urandom); step(); end
      done = N'(1) << ord[k]; step();
      check("cont_gap", grant, 0);
      done = '0;
      if (k == 4) req = '0;
      step();
    end

    // wrap-around: drive rr_ptr to 3, then 3 before 0
    req = 4'b0100; step();
    done = 4'b0100; step();
    done = '0; req = '0; step();
    check("wrap_ptr", rr_ptr_dbg, 3);
    req = 4'b1001; step();
    check("wrap_first", grant, 4'b1000);
    done = 4'b1000; step();
    done = '0; step();
    step();
    check("wrap_second", grant, 4'b0001);
    done = 4'b0001; step();
    done = '0; req = '0; step();

    // non-granted drawer's done/plot must be ignored
    req = 4'b0010; step();
    req = '0; plot_in = 4'b0100; done = 4'b0100;
    repeat (4) begin
      rand_pix(); step();
      check("ignore_grant", grant, 4'b0010);
      check("ignore_plot", vga_plot, 0);
    end
    plot_in = '0; done = 4'b0010; step();
    done = '0; step();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      req     = N'($urandom);
      plot_in = N'($urandom);
      done    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      rand_pix();
      step();
    end
    req = '0; done = '0; plot_in = '0;
    repeat (TO + 3) step();

    // watchdog: granted drawer never signals done
    grant_cycles = 0; err_pulses = 0;
    req = 4'b0001; step();
    req = '0;
`ifdef DRAW_ARB_TIMEOUT_EN
    repeat (TO + 4) step();
    check("to_grant_cycles", grant_cycles, TO);
    check("to_err_pulses", err_pulses, 1);
`else
    repeat (999) step();
    check("hold_grant_cycles", grant_cycles, 1000);
    check("hold_err_pulses", err_pulses, 0);
    done = 4'b0001; step();
    done = '0; step();
`endif
    step();

    // reset in the middle of a grant
    req = 4'b1000; step();
    req = '0;
    repeat (9) begin rand_pix(); plot_in = N'($urandom); step(); end
    async_reset();
    req = 4'b0110; step();
    check("post_rst_grant", grant, 4'b0010);
    done = 4'b0010; step();
    done = '0; req = '0; step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
